hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//  Producer-side partner of the EXE-stage forwarding logic. Decides, in the ID stage,
//  when the pipeline must stall because forwarding cannot supply an operand.
//  Also freezes every stage while a MEM-stage SRAM access is outstanding, and
//  raises a one-cycle flush on a taken branch. Keeps saturating stall/freeze counters.
// PARAMETERS
//  REG_W     5      register index width; matches dest_MEM/dest_WB width
//  CNT_W     16     width of the stall_cnt/freeze_cnt performance counters
//  WAIT_MAX  255    freeze cycles allowed before mem_timeout is set
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      synchronous reset, active-high
//  forward_en     in   1      1 = EXE forwarding active, stall only on load-use
//  src1_ID        in   REG_W  first source register of the instruction in ID
//  src2_ID        in   REG_W  second source register of the instruction in ID
//  two_src_ID     in   1      src2_ID is a real operand
//  dest_EXE       in   REG_W  destination register of the instruction in EXE
//  WB_EN_EXE      in   1      EXE instruction writes back
//  MEM_R_EN_EXE   in   1      EXE instruction is a load
//  dest_MEM       in   REG_W  destination register of the instruction in MEM
//  WB_EN_MEM      in   1      MEM instruction writes back
//  MEM_ACC_MEM    in   1      MEM instruction is a load or store
//  mem_ready      in   1      SRAM controller has completed the MEM access
//  branch_taken   in   1      EXE resolved a taken branch
//  hazard_stall   out  1      hold PC and IF/ID; insert bubble into ID/EXE
//  freeze         out  1      hold every pipeline register, including PC
//  flush          out  1      squash IF/ID and ID/EXE contents
//  mem_timeout    out  1      sticky: a freeze lasted longer than WAIT_MAX
//  stall_cnt      out  CNT_W  cycles with hazard_stall=1; saturating
//  freeze_cnt     out  CNT_W  cycles with freeze=1; saturating
// BEHAVIOUR
//  - Match terms:
//      mE = WB_EN_EXE & ((src1_ID==dest_EXE) | (two_src_ID & src2_ID==dest_EXE))
//      mM = same term using WB_EN_MEM and dest_MEM
//  - raw_hazard = forward_en ? (mE & MEM_R_EN_EXE) : (mE | mM)
//  - FSM states: RUN, MEM_WAIT, LU_BUBBLE. All outputs are Mealy, combinational from
//    state and inputs, with no extra latency.
//  - RUN:
//      MEM_ACC_MEM & ~mem_ready -> freeze=1, next state MEM_WAIT.
//      Otherwise freeze=0, flush=branch_taken, hazard_stall=raw_hazard & ~branch_taken.
//      If forward_en & load-use stall -> next state LU_BUBBLE.
//  - LU_BUBBLE: exactly one cycle. Outputs are computed as in RUN.
//      Next state is RUN, or MEM_WAIT when a freeze condition is present.
//  - MEM_WAIT:
//      freeze=1 while mem_ready=0. flush=0 and hazard_stall=0; branch_taken is held
//      upstream and is evaluated again after the freeze.
//      On the cycle with mem_ready=1: freeze=0, RUN rules apply, next state RUN.
//  - Priority: freeze > flush > hazard_stall. The outputs are never asserted together.
//  - Wait counter:
//      Counts freeze cycles. Clears when freeze deasserts.
//      When the count reaches WAIT_MAX with freeze still 1, mem_timeout is set.
//      mem_timeout stays set until rst. The freeze itself continues (no abort).
//  - Counters increment by 1 per qualifying cycle and hold at 2^CNT_W-1 (no wrap).
//  - Reset values: state=RUN, all counters 0, mem_timeout=0.
//    While rst=1, every output is 0.
//  - Reset mid-freeze or mid-bubble: the next cycle is RUN with no residual outputs.
//  - Writes from the WB stage are not checked: the register file writes first-half.
// STRUCTURE
//  - Shared package holds:
//      hz_state_t enum {RUN, MEM_WAIT, LU_BUBBLE}
//      REG_W and CNT_W defaults
//  - One sub-module: sat_counter (CNT_W, inc, clr) -> count.
//    Instantiated for stall_cnt, freeze_cnt and the wait counter (wait counter uses clr).
// TESTING
//  1. forward_en=0, src1_ID=3, dest_EXE=3, WB_EN_EXE=1
//       -> hazard_stall=1 that cycle; stall_cnt 0->1.
//  2. forward_en=1, same match, MEM_R_EN_EXE=0 -> hazard_stall=0.
//     Then MEM_R_EN_EXE=1 -> one stall cycle; state LU_BUBBLE, then RUN.
//  3. MEM_ACC_MEM=1, mem_ready low for 4 cycles
//       -> freeze=1 for those 4 cycles, freeze=0 when mem_ready=1; freeze_cnt=4.
//  4. branch_taken=1 together with a raw hazard -> flush=1 and hazard_stall=0.
//     branch_taken during MEM_WAIT -> flush=0.
//  5. WAIT_MAX=8, mem_ready held low for 10 cycles
//       -> mem_timeout rises after the 8th freeze cycle and stays set until rst.
//  6. rst pulse during MEM_WAIT -> freeze=0 the next cycle; counters 0;
//     saturation of stall_cnt checked with CNT_W=3 (holds at 7).

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and default widths for the ID-stage hazard/stall control block.
package hazard_stall_unit_pkg;

    localparam int unsigned REG_W_DEFAULT = 5;
    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StLuBubble
    } hz_state_t;

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage stall/freeze/flush decision with load-use bubble tracking,
// SRAM wait timeout detection and saturating performance counters.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned REG_W    = REG_W_DEFAULT,
    parameter int unsigned CNT_W    = CNT_W_DEFAULT,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forward_en,
    input  logic [REG_W-1:0] src1_ID,
    input  logic [REG_W-1:0] src2_ID,
    input  logic             two_src_ID,
    input  logic [REG_W-1:0] dest_EXE,
    input  logic             WB_EN_EXE,
    input  logic             MEM_R_EN_EXE,
    input  logic [REG_W-1:0] dest_MEM,
    input  logic             WB_EN_MEM,
    input  logic             MEM_ACC_MEM,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             hazard_stall,
    output logic             freeze,
    output logic             flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);

    hz_state_t state_q, state_d;

    logic m_exe, m_mem, raw_hazard, freeze_cond;
    logic stall_c, freeze_c, flush_c;
    logic timeout_q;
    logic [CNT_W-1:0]  stall_cnt_q, freeze_cnt_q;
    logic [WAIT_W-1:0] wait_cnt;

    assign m_exe = WB_EN_EXE &
                   ((src1_ID == dest_EXE) | (two_src_ID & (src2_ID == dest_EXE)));
    assign m_mem = WB_EN_MEM &
                   ((src1_ID == dest_MEM) | (two_src_ID & (src2_ID == dest_MEM)));

    // With forwarding only a load in EXE cannot be bypassed in time.
    assign raw_hazard  = forward_en ? (m_exe & MEM_R_EN_EXE) : (m_exe | m_mem);
    assign freeze_cond = MEM_ACC_MEM & ~mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        freeze_c = 1'b0;
        flush_c  = 1'b0;
        stall_c  = 1'b0;
        unique case (state_q)
            StRun, StLuBubble: begin
                if (freeze_cond) begin
                    freeze_c = 1'b1;
                    state_d  = StMemWait;
                end else begin
                    flush_c = branch_taken;
                    stall_c = raw_hazard & ~branch_taken;
                    if ((state_q == StRun) && forward_en && stall_c) begin
                        state_d = StLuBubble;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StMemWait: begin
                // A branch seen here is held upstream and re-presented after the freeze.
                if (!mem_ready) begin
                    freeze_c = 1'b1;
                end else begin
                    flush_c = branch_taken;
                    stall_c = raw_hazard & ~branch_taken;
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    assign hazard_stall = stall_c & ~rst;
    assign freeze       = freeze_c & ~rst;
    assign flush        = flush_c & ~rst;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hazard_stall),
        .clr   (1'b0),
        .count (stall_cnt_q)
    );

    sat_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (freeze),
        .clr   (1'b0),
        .count (freeze_cnt_q)
    );

    sat_counter #(.CNT_W(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (freeze),
        .clr   (~freeze),
        .count (wait_cnt)
    );

    // Set at the edge closing the WAIT_MAX-th consecutive freeze cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (freeze && (wait_cnt >= WAIT_W'(WAIT_MAX - 1))) begin
            timeout_q <= 1'b1;
        end
    end

    assign mem_timeout = timeout_q & ~rst;
    assign stall_cnt   = rst ? '0 : stall_cnt_q;
    assign freeze_cnt  = rst ? '0 : freeze_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench: stimulus pushes hand-computed expectations, a monitor
// pops and compares them against the DUT outputs every cycle.
module tb_hazard_stall_unit;

    typedef struct packed {
        logic       hs;
        logic       fr;
        logic       fl;
        logic       to;
        logic [2:0] sc;
        logic [2:0] fc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, forward_en, two_src_ID, WB_EN_EXE, MEM_R_EN_EXE;
    logic       WB_EN_MEM, MEM_ACC_MEM, mem_ready, branch_taken;
    logic [4:0] src1_ID, src2_ID, dest_EXE, dest_MEM;
    logic       hazard_stall, freeze, flush, mem_timeout;
    logic [2:0] stall_cnt, freeze_cnt;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    hazard_stall_unit #(.REG_W(5), .CNT_W(3), .WAIT_MAX(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .forward_en   (forward_en),
        .src1_ID      (src1_ID),
        .src2_ID      (src2_ID),
        .two_src_ID   (two_src_ID),
        .dest_EXE     (dest_EXE),
        .WB_EN_EXE    (WB_EN_EXE),
        .MEM_R_EN_EXE (MEM_R_EN_EXE),
        .dest_MEM     (dest_MEM),
        .WB_EN_MEM    (WB_EN_MEM),
        .MEM_ACC_MEM  (MEM_ACC_MEM),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .hazard_stall (hazard_stall),
        .freeze       (freeze),
        .flush        (flush),
        .mem_timeout  (mem_timeout),
        .stall_cnt    (stall_cnt),
        .freeze_cnt   (freeze_cnt)
    );

    always #5 clk = ~clk;

    task automatic drv(input logic r, input logic fwd, input logic [4:0] s1,
                       input logic [4:0] s2, input logic two, input logic [4:0] de,
                       input logic we, input logic mr, input logic [4:0] dm,
                       input logic wm, input logic acc, input logic rdy, input logic br);
        rst = r; forward_en = fwd; src1_ID = s1; src2_ID = s2; two_src_ID = two;
        dest_EXE = de; WB_EN_EXE = we; MEM_R_EN_EXE = mr; dest_MEM = dm;
        WB_EN_MEM = wm; MEM_ACC_MEM = acc; mem_ready = rdy; branch_taken = br;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic go(input string name, input logic hs, input logic fr, input logic fl,
                      input logic to, input int sc, input int fc);
        exp_t e;
        e.hs = hs; e.fr = fr; e.fl = fl; e.to = to; e.sc = 3'(sc); e.fc = 3'(fc);
        exp_q.push_back(e);
        name_q.push_back(name);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t  e;
        exp_t  a;
        string n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                a = {hazard_stall, freeze, flush, mem_timeout, stall_cnt, freeze_cnt};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got hs=%b fr=%b fl=%b to=%b sc=%0d fc=%0d, want hs=%b fr=%b fl=%b to=%b sc=%0d fc=%0d",
                             n, a.hs, a.fr, a.fl, a.to, a.sc, a.fc,
                             e.hs, e.fr, e.fl, e.to, e.sc, e.fc);
                end
            end
        end
    end

    initial begin : stimulus
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        @(posedge clk);
        #1;
        go("reset", 0, 0, 0, 0, 0, 0);

        // Non-forwarding RAW hazards against EXE and MEM
        drv(0, 0, 3, 0, 0, 3, 1, 0, 0, 0, 0, 1, 0); go("t1_exe", 1, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 5, 1, 3, 0, 0, 5, 1, 0, 1, 0); go("t1_mem", 1, 0, 0, 0, 1, 0);
        drv(0, 0, 0, 5, 0, 3, 0, 0, 5, 1, 0, 1, 0); go("t1_two0", 0, 0, 0, 0, 2, 0);

        // Forwarding: only load-use stalls
        drv(0, 1, 3, 0, 0, 3, 1, 0, 3, 1, 0, 1, 0); go("t2_nolu", 0, 0, 0, 0, 2, 0);
        drv(0, 1, 3, 0, 0, 3, 1, 1, 3, 1, 0, 1, 0); go("t2_lu", 1, 0, 0, 0, 2, 0);
        drv(0, 1, 3, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0); go("t2_bubble", 0, 0, 0, 0, 3, 0);
        idle(); go("t2_run", 0, 0, 0, 0, 3, 0);

        // Four-cycle SRAM wait
        for (int k = 0; k < 4; k++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); go("t3_freeze", 0, 1, 0, 0, 3, k);
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); go("t3_release", 0, 0, 0, 0, 3, 4);

        // Branch vs hazard and vs freeze
        drv(0, 0, 3, 0, 0, 3, 1, 0, 0, 0, 0, 1, 1); go("t4_branch", 0, 0, 1, 0, 3, 4);
        drv(0, 0, 3, 0, 0, 3, 1, 0, 0, 0, 1, 0, 1); go("t4_frz_a", 0, 1, 0, 0, 3, 4);
        drv(0, 0, 3, 0, 0, 3, 1, 0, 0, 0, 1, 0, 1); go("t4_frz_b", 0, 1, 0, 0, 3, 5);
        drv(0, 0, 3, 0, 0, 3, 1, 0, 0, 0, 1, 1, 1); go("t4_rel_br", 0, 0, 1, 0, 3, 6);
        drv(0, 0, 3, 0, 0, 3, 1, 0, 0, 0, 1, 0, 0); go("t4_frz_c", 0, 1, 0, 0, 3, 6);
        drv(0, 0, 3, 0, 0, 3, 1, 0, 0, 0, 1, 1, 0); go("t4_rel_haz", 1, 0, 0, 0, 3, 7);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); go("fc_sat_a", 0, 1, 0, 0, 4, 7);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); go("fc_sat_b", 0, 0, 0, 0, 4, 7);

        // Timeout after eight freeze cycles, sticky
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); go("t5_rst", 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            go("t5_wait", 0, 1, 0, (k >= 9), 0, (k - 1 > 7) ? 7 : k - 1);
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); go("t5_release", 0, 0, 0, 1, 0, 7);
        idle(); go("t5_sticky", 0, 0, 0, 1, 0, 7);

        // Reset during MEM_WAIT
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); go("t6_frz", 0, 1, 0, 1, 0, 7);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); go("t6_in_rst", 0, 0, 0, 0, 0, 0);
        idle(); go("t6_after", 0, 0, 0, 0, 0, 0);

        // stall_cnt saturation at 7
        for (int k = 1; k <= 9; k++) begin
            drv(0, 0, 3, 0, 0, 3, 1, 0, 0, 0, 0, 1, 0);
            go("t6_sat", 1, 0, 0, 0, (k - 1 > 7) ? 7 : k - 1, 0);
        end
        idle(); go("t6_sat_hold", 0, 0, 0, 0, 7, 0);

        // Reset during the load-use bubble
        drv(0, 1, 3, 0, 0, 3, 1, 1, 0, 0, 0, 1, 0); go("lu_enter", 1, 0, 0, 0, 7, 0);
        drv(1, 1, 3, 0, 0, 3, 1, 1, 0, 0, 0, 1, 0); go("lu_rst", 0, 0, 0, 0, 0, 0);
        idle(); go("lu_after", 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
